// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: icache FSM states and default frame count
package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - datapath fetch and memory read signals of the instruction cache
interface icache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    // slave: the cache itself; master: datapath plus memory driving it
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-frame instruction cache; ICACHE_STATS_EN adds hit/miss counters
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic       CLK,
    input  logic       nRST,
    icache_if.slave    bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t    state;
    icache_state_t    state_nxt;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];
    logic [31:0]      miss_addr;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             lookup_hit;
    logic             start_fill;
    logic             fill_done;
    logic [1:0]       unused_offset;

    assign idx           = bus.imemaddr[2 +: IDX_W];
    assign tag           = bus.imemaddr[31 -: TAG_W];
    assign miss_idx      = miss_addr[2 +: IDX_W];
    assign miss_tag      = miss_addr[31 -: TAG_W];
    assign unused_offset = bus.imemaddr[1:0];
    assign lookup_hit    = valid[idx] && (tags[idx] == tag);
    assign fill_done     = (state == FILL) && !bus.iwait;

    always_comb begin
        state_nxt    = state;
        start_fill   = 1'b0;
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        case (state)
            IDLE: begin
                if (bus.imemREN) begin
                    if (lookup_hit) begin
                        bus.ihit     = 1'b1;
                        bus.imemload = data[idx];
                    end else begin
                        start_fill = 1'b1;
                        state_nxt  = FILL;
                    end
                end
            end
            FILL: begin
                // Fill runs on the latched address; datapath redirects wait for IDLE
                bus.iREN  = 1'b1;
                bus.iaddr = miss_addr;
                if (!bus.iwait) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
            valid     <= '0;
            for (int i = 0; i < SETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (start_fill) begin
                miss_addr <= {bus.imemaddr[31:2], 2'b00};
            end
            if (fill_done) begin
                valid[miss_idx] <= 1'b1;
                tags[miss_idx]  <= miss_tag;
                data[miss_idx]  <= bus.iload;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (bus.ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
